// File: rtl/uart_tx_periph_pkg.sv
// uart_tx_periph_pkg -- shared definitions for the UART transmitter peripheral.
//   UART_BASE_ADDRESS  : register window, compared against addr[31:4]
//   uart_reg_address_t : register offsets within the window (addr[3:0])
//   uart_tx_state_t    : serializer FSM states
//   ST_* / CT_*        : STATUS and CTRL bit positions
//   eff_div()          : divider sanitizing (0 behaves as 1)
package uart_tx_periph_pkg;

  // Window 0x1000_0000 .. 0x1000_000F
  localparam logic [27:0] UART_BASE_ADDRESS = 28'h100_0000;

  typedef enum logic [3:0] {
    UART_STATUS = 4'h0,
    UART_DATA   = 4'h4,
    UART_CTRL   = 4'h8,
    UART_BAUD   = 4'hC
  } uart_reg_address_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } uart_tx_state_t;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  localparam int CT_TXEN  = 0;
  localparam int CT_IRQEN = 1;
  localparam int CT_PAR   = 2;
  localparam int CT_ODD   = 3;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- synchronous byte FIFO for the UART transmitter.
//   clk, rst   : clock, asynchronous active-high reset
//   push/wdata : enqueue a byte; accepted when not full, or when full and
//                a pop happens in the same cycle
//   pop        : dequeue the head byte (ignored when empty)
//   rdata      : current head byte (combinational)
//   full/empty : derived from pointers carrying an extra wrap bit
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // When full, the pop frees the slot the push lands in on the same edge;
  // the head is read combinationally before that write.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph -- memory-mapped 8N1 UART transmitter.
//   clk, rst  : core clock, asynchronous active-high reset
//   addr_i    : LSU byte address; window selected by addr_i[31:4]
//   wdata_i   : store data, we_i store strobe, re_i load strobe
//   rdata_o   : combinational load data (0 unless re_i & sel_o)
//   sel_o     : window hit
//   tx_o      : serial line, idle high, LSB first
//   irq_o     : registered TX-done interrupt (irq_en & FIFO empty & idle)
// Registers: STATUS 0x0, DATA 0x4 (write-only), CTRL 0x8, BAUD 0xC.
// Build option: define UART_PARITY_EN to enable CTRL parity_en/odd and the
// PARITY bit between the data bits and the stop bit.
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter int          FIFO_DEPTH       = 4,
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic        sel_o,
  output logic        tx_o,
  output logic        irq_o
);

`ifdef UART_PARITY_EN
  localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
  localparam logic [3:0] CTRL_WMASK = 4'h3;
`endif

  uart_reg_address_t reg_off;
  logic              wr_hit, wr_status, wr_data, wr_ctrl, wr_baud;

  logic [3:0]  ctrl_q;
  logic [15:0] baud_q;
  logic        ovf_q;
  logic        irq_q;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;

  uart_tx_state_t state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [15:0] div_q, div_n;
  logic [2:0]  bit_q, bit_n;
  logic [7:0]  shift_q, shift_n;
  logic        par_en_q, par_en_n;
  logic        par_bit_q, par_bit_n;
  logic        bit_end;
  logic        busy;

  // ---------------- decode ----------------
  assign sel_o     = (addr_i[31:4] == UART_BASE_ADDRESS);
  assign reg_off   = uart_reg_address_t'(addr_i[3:0]);
  assign wr_hit    = we_i & sel_o;
  assign wr_status = wr_hit & (reg_off == UART_STATUS);
  assign wr_data   = wr_hit & (reg_off == UART_DATA);
  assign wr_ctrl   = wr_hit & (reg_off == UART_CTRL);
  assign wr_baud   = wr_hit & (reg_off == UART_BAUD);

  assign busy = (state_q != IDLE);

  always_comb begin
    rdata_o = '0;
    if (re_i & sel_o) begin
      case (reg_off)
        UART_STATUS: begin
          rdata_o[ST_BUSY]  = busy;
          rdata_o[ST_FULL]  = fifo_full;
          rdata_o[ST_EMPTY] = fifo_empty;
          rdata_o[ST_OVF]   = ovf_q;
        end
        UART_CTRL:   rdata_o[3:0]  = ctrl_q;
        UART_BAUD:   rdata_o[15:0] = baud_q;
        default:     rdata_o       = '0;
      endcase
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      baud_q <= DEFAULT_BAUD_DIV;
      ovf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= wdata_i[3:0] & CTRL_WMASK;
      if (wr_baud) baud_q <= wdata_i[15:0];
      // A dropped byte wins over a same-cycle clear so it is never lost silently.
      if (wr_data & fifo_full & ~fifo_pop)    ovf_q <= 1'b1;
      else if (wr_status & wdata_i[ST_OVF])   ovf_q <= 1'b0;
      irq_q <= ctrl_q[CT_IRQEN] & fifo_empty & (state_q == IDLE);
    end
  end

  assign irq_o = irq_q;

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .wdata (wdata_i[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- serializer FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 16'd1;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      div_q     <= div_n;
      bit_q     <= bit_n;
      shift_q   <= shift_n;
      par_en_q  <= par_en_n;
      par_bit_q <= par_bit_n;
    end
  end

  assign bit_end = (cnt_q == div_q - 16'd1);

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    div_n     = div_q;
    bit_n     = bit_q;
    shift_n   = shift_q;
    par_en_n  = par_en_q;
    par_bit_n = par_bit_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        // Divider and parity mode are frozen for the whole frame.
        if (ctrl_q[CT_TXEN] && !fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_n   = fifo_rdata;
          div_n     = eff_div(baud_q);
          cnt_n     = '0;
          bit_n     = '0;
`ifdef UART_PARITY_EN
          par_en_n  = ctrl_q[CT_PAR];
`else
          par_en_n  = 1'b0;
`endif
          par_bit_n = (^fifo_rdata) ^ ctrl_q[CT_ODD];
          state_n   = START;
        end
      end
      default: begin
        if (!bit_end) begin
          cnt_n = cnt_q + 16'd1;
        end else begin
          cnt_n = '0;
          case (state_q)
            START: state_n = DATA;
            DATA: begin
              shift_n = {1'b0, shift_q[7:1]};
              bit_n   = bit_q + 3'd1;
              if (bit_q == 3'd7) state_n = par_en_q ? PARITY : STOP;
            end
            PARITY:  state_n = STOP;
            default: state_n = IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[0];
      PARITY:  tx_o = par_bit_q;
      default: tx_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph -- scoreboard bench for uart_tx_periph.
// Stimulus pushes expected load data, expected serial frames and signal
// probes into queues; one monitor process on the falling clock edge pops
// and compares them as the DUT produces loads and frames.
module tb_uart_tx_periph;
  import uart_tx_periph_pkg::*;

  localparam logic [31:0] BASE = {UART_BASE_ADDRESS, 4'h0};
  localparam int P_TX = 0, P_IRQ = 1, P_SEL = 2, P_TIMEOUT = 3, P_DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, sel, tx, irq;

  always #5 clk = ~clk;

  uart_tx_periph #(.FIFO_DEPTH(4), .DEFAULT_BAUD_DIV(16'd434)) dut (
    .clk(clk), .rst(rst), .addr_i(addr), .wdata_i(wdata), .we_i(we), .re_i(re),
    .rdata_o(rdata), .sel_o(sel), .tx_o(tx), .irq_o(irq)
  );

  typedef struct { logic [10:0] bits; int nbits; int div; int gap; } frame_t;
  typedef struct { logic [31:0] exp; string name; } rd_exp_t;
  typedef struct { int sig; logic exp; string name; } probe_t;

  frame_t  frame_q[$];
  rd_exp_t rd_q[$];
  probe_t  probe_q[$];

  int tests = 0, fails = 0;
  int frames_done = 0;
  int neg_cnt = 0, last_start = 0;
  bit in_frame = 0, stray = 0, ok;
  int bi, ci;
  frame_t cur;
  logic [10:0] got;
  rd_exp_t r;
  probe_t  p;

  // par: 0 none, 1 even, 2 odd
  function automatic frame_t mk(input logic [7:0] d, input int div, input int gap, input int par);
    frame_t f;
    f.bits = '1;
    f.bits[0] = 1'b0;
    f.bits[8:1] = d;
    f.nbits = 10;
    if (par != 0) begin
      f.bits[9] = (^d) ^ (par == 2);
      f.nbits = 11;
    end
    f.div = div;
    f.gap = gap;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      neg_cnt++;
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        case (p.sig)
          P_TX:    chk(p.name, {31'b0, tx},  {31'b0, p.exp});
          P_IRQ:   chk(p.name, {31'b0, irq}, {31'b0, p.exp});
          P_SEL:   chk(p.name, {31'b0, sel}, {31'b0, p.exp});
          P_DRAIN: chk(p.name, 32'(frame_q.size() + rd_q.size()), 32'd0);
          default: begin
            tests++; fails++;
            $display("FAIL %s: wait bound expired at cycle %0d", p.name, neg_cnt);
          end
        endcase
      end
      if (re) begin
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_unexpected: got 0x%0h, expected no load", rdata);
        end else begin
          r = rd_q.pop_front();
          chk(r.name, rdata, r.exp);
        end
      end
      if (rst) begin
        in_frame = 0;   // reset aborts the frame in flight
      end else if (stray) begin
        if (tx === 1'b1) stray = 0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          if (frame_q.size() == 0) begin
            tests++; fails++; stray = 1;
            $display("FAIL tx_unexpected: start bit at cycle %0d, expected idle line", neg_cnt);
          end else begin
            cur = frame_q.pop_front();
            if (cur.gap != 0) chk("frame_gap", 32'(neg_cnt - last_start), 32'(cur.gap));
            last_start = neg_cnt;
            bi = 0; ci = 0; ok = 1; got = '1; got[0] = tx;
            in_frame = 1;
          end
        end
      end else begin
        ci++;
        if (ci == cur.div) begin ci = 0; bi++; end
        if (tx !== cur.bits[bi]) ok = 0;
        got[bi] = tx;
        if (bi == cur.nbits - 1 && ci == cur.div - 1) begin
          tests++;
          if (!ok) begin
            fails++;
            $display("FAIL tx_frame: got bits %b, expected %b (div %0d, LSB = start)",
                     got, cur.bits, cur.div);
          end
          in_frame = 0;
          frames_done++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic probe(input int sig, input logic exp, input string name);
    probe_t q;
    q.sig = sig; q.exp = exp; q.name = name;
    probe_q.push_back(q);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_raw(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    wr_raw(BASE | {28'b0, off}, d);
  endtask

  task automatic rd_raw(input logic [31:0] a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.exp = exp; e.name = name;
    rd_q.push_back(e);
    addr = a; re = 1'b1;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string name);
    rd_raw(BASE | {28'b0, off}, exp, name);
  endtask

  task automatic send(input frame_t f);
    frame_q.push_back(f);
    wr(4'h4, {24'b0, f.bits[8:1]});
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((frame_q.size() != 0 || in_frame) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (n >= budget) probe(P_TIMEOUT, 1'b0, name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fd0, n;
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    #1;
    probe(P_TX,  1'b1, "reset_tx");
    probe(P_IRQ, 1'b0, "reset_irq");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values and decode
    rd(4'h0, 32'h4,   "reset_status");
    rd(4'hC, 32'h1B2, "reset_baud");
    rd(4'h8, 32'h0,   "reset_ctrl");
    rd(4'h2, 32'h0,   "unmapped_read");
    probe(P_SEL, 1'b0, "sel_miss");
    rd_raw(32'h2000_0000, 32'h0, "outside_window_read");
    wr(4'hC, 32'hFFFF_0004);
    rd(4'hC, 32'h4, "baud_upper_bits");
    wr_raw(32'h2000_000C, 32'h7);
    rd(4'hC, 32'h4, "outside_write_ignored");

    // Single frame 0xA5 at div 4
    wr(4'h8, 32'h1);
    send(mk(8'hA5, 4, 0, 0));
    idle(3);
    rd(4'h0, 32'h5, "status_busy");
    rd(4'h4, 32'h0, "data_reads_zero");
    wait_idle(2000, "frame_a5_wait");

    // Overflow, sticky clear, back-to-back frames
    wr(4'h8, 32'h0);
    wr(4'h4, 32'h11); wr(4'h4, 32'h22); wr(4'h4, 32'h33); wr(4'h4, 32'h44);
    wr(4'h4, 32'h55);
    rd(4'h0, 32'hA, "status_full_ovf");
    wr(4'h0, 32'h8);
    rd(4'h0, 32'h2, "status_ovf_cleared");
    frame_q.push_back(mk(8'h11, 4, 0, 0));
    frame_q.push_back(mk(8'h22, 4, 41, 0));
    frame_q.push_back(mk(8'h33, 4, 41, 0));
    frame_q.push_back(mk(8'h44, 4, 41, 0));
    wr(4'h8, 32'h1);
    wait_idle(2000, "burst_wait");

    // Interrupt timing
    send(mk(8'h5A, 4, 0, 0));
    idle(8);
    wr(4'h8, 32'h3);
    probe(P_IRQ, 1'b0, "irq_low_while_busy");
    fd0 = frames_done; n = 0;
    while (frames_done == fd0 && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) probe(P_TIMEOUT, 1'b0, "irq_frame_wait");
    probe(P_IRQ, 1'b0, "irq_registered_lag");
    idle(1);
    probe(P_IRQ, 1'b1, "irq_rise");
    frame_q.push_back(mk(8'h81, 4, 0, 0));
    wr(4'h4, 32'h81);
    probe(P_IRQ, 1'b1, "irq_hold_on_push");
    idle(1);
    probe(P_IRQ, 1'b0, "irq_fall");
    wait_idle(2000, "irq_tail_wait");
    wr(4'h8, 32'h1);

    // Divider change mid-frame applies to the next frame only
    frame_q.push_back(mk(8'h3C, 4, 0, 0));
    frame_q.push_back(mk(8'hC3, 8, 41, 0));
    wr(4'h4, 32'h3C);
    wr(4'h4, 32'hC3);
    idle(8);
    wr(4'hC, 32'h8);
    wait_idle(3000, "baud_change_wait");

    // Divider of 0 behaves as 1
    wr(4'hC, 32'h0);
    send(mk(8'h96, 1, 0, 0));
    wait_idle(500, "div0_wait");

    // Reset in the middle of the data bits
    wr(4'hC, 32'h4);
    send(mk(8'h0F, 4, 0, 0));
    idle(20);
    rst = 1'b1;
    probe(P_TX, 1'b1, "reset_midframe_tx");
    idle(1);
    rst = 1'b0;
    rd(4'h0, 32'h4,   "status_after_reset");
    rd(4'hC, 32'h1B2, "baud_after_reset");

    // Parity option
    wr(4'hC, 32'h4);
`ifdef UART_PARITY_EN
    wr(4'h8, 32'h5);
    rd(4'h8, 32'h5, "ctrl_parity_even");
    send(mk(8'h07, 4, 0, 1));
    wait_idle(2000, "parity_even_wait");
    wr(4'h8, 32'hD);
    send(mk(8'h07, 4, 0, 2));
    wait_idle(2000, "parity_odd_wait");
`else
    wr(4'h8, 32'hF);
    rd(4'h8, 32'h3, "ctrl_mask");
    send(mk(8'h07, 4, 0, 0));
    wait_idle(2000, "no_parity_wait");
`endif
    wr(4'h8, 32'h0);

    idle(3);
    probe(P_DRAIN, 1'b0, "scoreboard_drained");
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
